paddle_pos_ctrl: RTL and testbench

Generates the paddle's vertical position (`y_pos`) from the player's up/down pushbuttons, updating once per video frame during vertical blanking. It synchronizes and debounces the buttons and runs a small direction/acceleration state machine. The position is clamped to the visible field. Its `y_pos` output drives the paddle renderer's `y_pos` input directly, in the same pixel-clock domain as the VGA timing counters.

---
 rtl/paddle_pos_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_paddle_pos_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_pos_ctrl.sv
// Paddle vertical position controller: button sync/debounce, per-frame
// direction/acceleration FSM and clamped position update during vblank.
module paddle_pos_ctrl #(
    parameter logic [9:0]  SCREEN_HEIGHT   = 10'd480,
    parameter logic [9:0]  PADDLE_HEIGHT   = 10'd48,
    parameter logic [9:0]  Y_INIT          = 10'd216,
    parameter logic [9:0]  STEP            = 10'd4,
    parameter logic [9:0]  FAST_STEP       = 10'd8,
    parameter logic [7:0]  ACCEL_FRAMES    = 8'd16,
    parameter logic [3:0]  DEBOUNCE_FRAMES = 4'd2,
    parameter logic [10:0] V_TICK          = 11'd480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        enable,
    input  logic        recenter,
    output logic [31:0] y_pos,
    output logic        frame_tick,
    output logic        at_top,
    output logic        at_bottom
);

    localparam logic [9:0] YMAX = SCREEN_HEIGHT - PADDLE_HEIGHT;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    logic       up_meta_r;
    logic       up_sync_r;
    logic       dn_meta_r;
    logic       dn_sync_r;
    logic       frame_tick_r;
    logic [3:0] up_cnt_r;
    logic [3:0] dn_cnt_r;
    logic       up_flag_r;
    logic       dn_flag_r;
    logic [1:0] state_r;
    logic [7:0] hold_cnt_r;
    logic [9:0] y_r;

    logic [3:0] up_cnt_nxt_s;
    logic [3:0] dn_cnt_nxt_s;
    logic [1:0] dir_next_s;
    logic [9:0] step_s;
    logic [1:0] state_nxt_s;
    logic [7:0] hold_nxt_s;
    logic [9:0] y_nxt_s;

    function automatic logic [3:0] deb_next(input logic lvl, input logic [3:0] cnt);
        if (!lvl) begin
            return 4'd0;
        end else if (cnt >= DEBOUNCE_FRAMES) begin
            return DEBOUNCE_FRAMES;
        end else begin
            return cnt + 4'd1;
        end
    endfunction

    // Clamped move: up saturates at row 0, down saturates at YMAX.
    function automatic logic [9:0] move_y(input logic [9:0] y, input logic [1:0] dir,
                                          input logic [9:0] step);
        logic [10:0] sum;
        sum = {1'b0, y} + {1'b0, step};
        case (dir)
            ST_UP:   return (y < step) ? 10'd0 : (y - step);
            ST_DOWN: return (sum > {1'b0, YMAX}) ? YMAX : sum[9:0];
            default: return y;
        endcase
    endfunction

    // Two-flop synchronizers for the asynchronous pushbuttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_meta_r <= 1'b0;
            up_sync_r <= 1'b0;
            dn_meta_r <= 1'b0;
            dn_sync_r <= 1'b0;
        end else begin
            up_meta_r <= btn_up;
            up_sync_r <= up_meta_r;
            dn_meta_r <= btn_down;
            dn_sync_r <= dn_meta_r;
        end
    end

    // Frame tick, one cycle after the raster reaches column 0 of V_TICK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= (hcount == 11'd0) && (vcount == V_TICK);
        end
    end

    assign up_cnt_nxt_s = deb_next(up_sync_r, up_cnt_r);
    assign dn_cnt_nxt_s = deb_next(dn_sync_r, dn_cnt_r);

    // Debounce counters and qualified flags, advanced once per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_cnt_r  <= 4'd0;
            dn_cnt_r  <= 4'd0;
            up_flag_r <= 1'b0;
            dn_flag_r <= 1'b0;
        end else if (frame_tick_r) begin
            up_cnt_r  <= up_cnt_nxt_s;
            dn_cnt_r  <= dn_cnt_nxt_s;
            up_flag_r <= (up_cnt_nxt_s == DEBOUNCE_FRAMES);
            dn_flag_r <= (dn_cnt_nxt_s == DEBOUNCE_FRAMES);
        end else begin
            up_cnt_r  <= up_cnt_r;
            dn_cnt_r  <= dn_cnt_r;
            up_flag_r <= up_flag_r;
            dn_flag_r <= dn_flag_r;
        end
    end

    // Requested direction from the flags as they stood before this edge.
    always_comb begin
        case ({up_flag_r, dn_flag_r})
            2'b10:   dir_next_s = ST_UP;
            2'b01:   dir_next_s = ST_DOWN;
            default: dir_next_s = ST_IDLE;
        endcase
    end

    // Next state, hold count and position; recenter beats a coincident tick.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_cnt_r;
        y_nxt_s     = y_r;
        step_s      = STEP;
        if (recenter) begin
            state_nxt_s = ST_IDLE;
            hold_nxt_s  = 8'd0;
            y_nxt_s     = Y_INIT;
        end else if (frame_tick_r) begin
            if (!enable || (dir_next_s == ST_IDLE)) begin
                state_nxt_s = ST_IDLE;
                hold_nxt_s  = 8'd0;
            end else if (dir_next_s == state_r) begin
                step_s      = (hold_cnt_r >= ACCEL_FRAMES) ? FAST_STEP : STEP;
                hold_nxt_s  = (hold_cnt_r == 8'd255) ? 8'd255 : (hold_cnt_r + 8'd1);
                y_nxt_s     = move_y(y_r, dir_next_s, step_s);
            end else begin
                step_s      = STEP;
                state_nxt_s = dir_next_s;
                hold_nxt_s  = 8'd0;
                y_nxt_s     = move_y(y_r, dir_next_s, step_s);
            end
        end else begin
            state_nxt_s = state_r;
            hold_nxt_s  = hold_cnt_r;
            y_nxt_s     = y_r;
        end
    end

    // Movement state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 8'd0;
            y_r        <= Y_INIT;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            y_r        <= y_nxt_s;
        end
    end

    assign y_pos      = {22'd0, y_r};
    assign frame_tick = frame_tick_r;
    assign at_top     = (y_r == 10'd0);
    assign at_bottom  = (y_r == YMAX);

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Randomized bench for paddle_pos_ctrl against a per-frame behavioural model.
module tb_paddle_pos_ctrl;

    localparam int YMAX  = 432;
    localparam int YINIT = 216;
    localparam int DEB   = 2;
    localparam int ACC   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = 11'd0;
    logic [10:0] vcount = 11'd0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        enable = 1'b1;
    logic        recenter = 1'b0;
    logic [31:0] y_pos;
    logic        frame_tick;
    logic        at_top;
    logic        at_bottom;

    always #5 clk = ~clk;

    paddle_pos_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .enable     (enable),
        .recenter   (recenter),
        .y_pos      (y_pos),
        .frame_tick (frame_tick),
        .at_top     (at_top),
        .at_bottom  (at_bottom)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: run lengths, qualified flags, direction, same-direction ticks.
    int m_y, m_dir, m_same, up_run, dn_run;
    bit m_qu, m_qd, ft_exp;
    bit u_d1, u_d2, d_d1, d_d2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y = YINIT; m_dir = 0; m_same = 0; up_run = 0; dn_run = 0;
        m_qu = 1'b0; m_qd = 1'b0; ft_exp = 1'b0;
        u_d1 = 1'b0; u_d2 = 1'b0; d_d1 = 1'b0; d_d2 = 1'b0;
    endtask

    // One clock: drive inputs, advance the model for this edge, then compare.
    task automatic cyc(input logic [10:0] h, input logic [10:0] v, input bit rc);
        int dir, step;
        hcount = h; vcount = v; recenter = rc;
        @(posedge clk);
        if (ft_exp) begin
            dir = (m_qu && !m_qd) ? 1 : ((m_qd && !m_qu) ? 2 : 0);
            up_run = u_d2 ? ((up_run < 1000) ? up_run + 1 : up_run) : 0;
            dn_run = d_d2 ? ((dn_run < 1000) ? dn_run + 1 : dn_run) : 0;
            m_qu = (up_run >= DEB);
            m_qd = (dn_run >= DEB);
            if (!rc) begin
                if (!enable || dir == 0) begin
                    m_dir = 0; m_same = 0;
                end else begin
                    if (dir == m_dir) begin
                        step = (m_same >= ACC) ? 8 : 4;
                        if (m_same < 255) m_same++;
                    end else begin
                        step = 4; m_same = 0; m_dir = dir;
                    end
                    if (dir == 1) m_y = (m_y < step) ? 0 : m_y - step;
                    else          m_y = (m_y + step > YMAX) ? YMAX : m_y + step;
                end
            end
        end
        if (rc) begin
            m_y = YINIT; m_dir = 0; m_same = 0;
        end
        u_d2 = u_d1; u_d1 = btn_up;
        d_d2 = d_d1; d_d1 = btn_down;
        ft_exp = (h == 11'd0) && (v == 11'd480);
        #1;
        check("frame_tick", {31'd0, frame_tick}, {31'd0, ft_exp});
        check("y_pos", y_pos, m_y);
        check("at_top", {31'd0, at_top}, (m_y == 0) ? 32'd1 : 32'd0);
        check("at_bottom", {31'd0, at_bottom}, (m_y == YMAX) ? 32'd1 : 32'd0);
        recenter = 1'b0;
    endtask

    task automatic idle_hv(output logic [10:0] h, output logic [10:0] v);
        h = 11'($urandom_range(0, 799));
        v = 11'($urandom_range(0, 524));
        if (h == 11'd0 && v == 11'd480) h = 11'd1;
    endtask

    // Compressed frame: idle raster (with near-miss positions), tick position, tick edge.
    task automatic frame(input int n_idle, input bit rc_tick);
        logic [10:0] h, v;
        for (int i = 0; i < n_idle; i++) begin
            if (i == 0)      begin h = 11'd1; v = 11'd480; end
            else if (i == 1) begin h = 11'd0; v = 11'd479; end
            else             idle_hv(h, v);
            cyc(h, v, 1'b0);
        end
        cyc(11'd0, 11'd480, 1'b0);
        idle_hv(h, v);
        cyc(h, v, rc_tick);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_y_pos", y_pos, YINIT);
        check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        check("rst_at_top", {31'd0, at_top}, 32'd0);
        check("rst_at_bottom", {31'd0, at_bottom}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic rc_pulse();
        logic [10:0] h, v;
        idle_hv(h, v);
        cyc(h, v, 1'b1);
    endtask

    initial begin
        model_reset();
        #12;
        check("init_y_pos", y_pos, YINIT);
        check("init_frame_tick", {31'd0, frame_tick}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Down hold from before tick 1: acceleration then bottom clamp.
        btn_down = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            frame(4, 1'b0);
            if (t == 2)  check("down_t2", y_pos, 216);
            if (t == 3)  check("down_t3", y_pos, 220);
            if (t == 19) check("down_t19", y_pos, 284);
            if (t == 20) check("down_t20", y_pos, 292);
        end
        for (int t = 0; t < 25; t++) frame(4, 1'b0);
        check("bottom_y", y_pos, 432);
        check("bottom_flag", {31'd0, at_bottom}, 32'd1);
        btn_down = 1'b0;
        for (int t = 0; t < 3; t++) frame(4, 1'b0);

        // Up hold from centre to the top clamp.
        rc_pulse();
        check("recenter_y", y_pos, 216);
        btn_up = 1'b1;
        for (int t = 1; t <= 43; t++) begin
            frame(4, 1'b0);
            if (t == 19) check("up_t19", y_pos, 148);
            if (t == 37) check("up_t37", y_pos, 4);
            if (t == 38) begin
                check("up_t38", y_pos, 0);
                check("up_t38_top", {31'd0, at_top}, 32'd1);
            end
        end
        check("top_stays", y_pos, 0);
        btn_up = 1'b0;
        for (int t = 0; t < 3; t++) frame(4, 1'b0);

        // Single-sample glitch, then both buttons, then release down.
        rc_pulse();
        btn_up = 1'b1;
        frame(4, 1'b0);
        btn_up = 1'b0;
        for (int t = 0; t < 4; t++) frame(4, 1'b0);
        check("glitch_y", y_pos, 216);
        btn_up = 1'b1; btn_down = 1'b1;
        for (int t = 0; t < 6; t++) frame(4, 1'b0);
        check("both_y", y_pos, 216);
        btn_down = 1'b0;
        frame(4, 1'b0);
        check("release_tick_y", y_pos, 216);
        frame(4, 1'b0);
        check("after_both_1", y_pos, 212);
        frame(4, 1'b0);
        check("after_both_2", y_pos, 208);

        // Enable gating, then recenter coincident with a tick.
        btn_up = 1'b0; enable = 1'b0; btn_down = 1'b1;
        for (int t = 0; t < 6; t++) frame(4, 1'b0);
        check("frozen_y", y_pos, 208);
        enable = 1'b1;
        frame(4, 1'b0);
        check("enable_1", y_pos, 212);
        frame(4, 1'b0);
        check("enable_2", y_pos, 216);
        for (int t = 0; t < 20; t++) frame(4, 1'b0);
        frame(4, 1'b1);
        check("rc_tick_y", y_pos, 216);
        frame(4, 1'b0);
        check("rc_next_1", y_pos, 220);
        frame(4, 1'b0);
        check("rc_next_2", y_pos, 224);

        // Asynchronous reset while the tick is high and down is held.
        cyc(11'd0, 11'd480, 1'b0);
        do_reset();
        for (int t = 0; t < 5; t++) frame(4, 1'b0);

        // Randomized play.
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 3) == 0) btn_down = ~btn_down;
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) rc_pulse();
            frame($urandom_range(2, 6), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
